bm_product_accumulator: RTL and testbench
=========================================

BM_PRODUCT_ACCUMULATOR -- requirements
Module: bm_product_accumulator

Interface
REQ-001 The block SHALL have parameter E, default 3, the BM operand exponent width.
REQ-002 The block SHALL have parameter M, default 4, the BM operand mantissa width.
REQ-003 The block SHALL have parameter SB_SIZE, default 3, the shared-bias width.
REQ-004 The block SHALL have parameter ACC_W, default 32, the accumulator width; legal only if ACC_W >= 2M+2+2^(E+1).
REQ-005 The block SHALL have parameter CNT_W, default 8, the term-counter width.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-007 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 The block SHALL have port in_valid  input  1  product beat valid.
REQ-009 The block SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready at a clk edge.
REQ-010 The block SHALL have port product  input  2M+E+4  multiplier result {sign, exp[E:0], man[2M+1:0]}.
REQ-011 The block SHALL have port in_shared_bias  input  SB_SIZE  signed shared bias of the beat.
REQ-012 The block SHALL have port in_exp_overflow  input  1  multiplier exponent-overflow flag of the beat.
REQ-013 The block SHALL have port in_last  input  1  marks final term of the dot product.
REQ-014 The block SHALL have port out_valid  output  1  result valid.
REQ-015 The block SHALL have port out_ready  input  1  result consumed when out_valid & out_ready at a clk edge.
REQ-016 The block SHALL have port acc_out  output  ACC_W  signed two's-complement dot-product sum.
REQ-017 The block SHALL have port out_shared_bias  output  SB_SIZE  signed bias captured on the first beat.
REQ-018 The block SHALL have port term_count  output  CNT_W  number of accepted beats, saturating at 2^CNT_W-1.
REQ-019 The block SHALL have port out_overflow  output  1  sticky: any in_exp_overflow or accumulator saturation.
REQ-020 The block SHALL have port out_bias_err  output  1  sticky: a beat's in_shared_bias differed from the captured bias.

Function
REQ-021 The block SHALL implement states IDLE (no beat yet), ACCUM (≥1 beat accepted, in_last not seen), DONE (result held).
REQ-022 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DONE; out_valid SHALL be 1 only in DONE.
REQ-023 Each beat SHALL be converted to term = (-1)^sign × (man << exp), exp unsigned 0..2^(E+1)-1, sign-extended to ACC_W bits.
REQ-024 On an accepted beat in IDLE, acc SHALL load term (not add), bias SHALL be captured, count SHALL be 1, flags SHALL be set from this beat only.
REQ-025 On an accepted beat in ACCUM, acc SHALL become acc+term, evaluated at ACC_W+1 bits.
REQ-026 If the sum exceeds 2^(ACC_W-1)-1 or is below -2^(ACC_W-1), acc SHALL clamp to that bound and out_overflow SHALL set.
REQ-027 An accepted beat with in_last=1 SHALL move the FSM to DONE; acc_out, term_count, flags SHALL be valid the next cycle (latency 1 clk).
REQ-028 In DONE, all outputs SHALL hold stable until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-029 No beat SHALL be accepted on the DONE→IDLE edge; the next beat is accepted one cycle later at earliest.
REQ-030 term_count SHALL stop incrementing at 2^CNT_W-1 without affecting accumulation.
REQ-031 Beats with in_valid=0 SHALL leave all state unchanged.

Reset
REQ-032 rst_n=0 SHALL immediately, regardless of clk, force state IDLE, acc_out=0, out_shared_bias=0, term_count=0, out_overflow=0, out_bias_err=0, out_valid=0, in_ready=1.
REQ-033 Reset asserted mid-accumulation or in DONE SHALL discard the partial/held result; no out_valid pulse SHALL follow.

Verification
REQ-034 Defaults; beats {0,exp0,man256}, {1,exp1,man256}, {0,exp2,man300,last}, bias 2 -> acc_out=944, term_count=3, out_shared_bias=2, flags 0, out_valid 1 cycle after last.
REQ-035 Single beat {1,exp15,man1023,last} -> acc_out=-33521664, term_count=1.
REQ-036 65 beats {0,exp15,man1023}, 65th last -> acc_out=2147483647, out_overflow=1, term_count=65.
REQ-037 Bias 1 on beat 1, bias -2 on beat 2 (last); in_exp_overflow=1 on beat 2 -> out_bias_err=1, out_overflow=1, out_shared_bias=1.
REQ-038 DONE with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, in_ready=0, no beat absorbed; out_ready=1 -> IDLE, next dot product starts from acc=0.
REQ-039 rst_n pulsed low between clk edges after 2 beats -> all outputs reset within the low phase, no out_valid, next beat restarts count at 1.

Source files
------------

// File: rtl/bm_product_accumulator.sv
// Accumulates a stream of block-minifloat multiplier products into a saturating
// two's-complement dot-product sum, with shared-bias capture and sticky error flags.
module bm_product_accumulator #(
  parameter int E       = 3,
  parameter int M       = 4,
  parameter int SB_SIZE = 3,
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*M+E+3:0]           product,
  input  logic signed [SB_SIZE-1:0]  in_shared_bias,
  input  logic                       in_exp_overflow,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    acc_out,
  output logic signed [SB_SIZE-1:0]  out_shared_bias,
  output logic [CNT_W-1:0]           term_count,
  output logic                       out_overflow,
  output logic                       out_bias_err
);

  localparam int EW = E + 1;
  localparam int MW = 2 * M + 2;
  localparam int PW = 2 * M + E + 4;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic                     p_sign;
  logic [EW-1:0]            p_exp;
  logic [MW-1:0]            p_man;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W:0]    sum_wide;
  logic                     sum_ovf;

  logic signed [ACC_W-1:0]   acc_p0;
  logic signed [SB_SIZE-1:0] bias_p0;
  logic [CNT_W-1:0]          cnt_p0;
  logic                      ovf_p0;
  logic                      berr_p0;

  // Magnitude is man << exp; ACC_W is sized so the shifted magnitude never reaches the sign bit.
  function automatic logic signed [ACC_W-1:0] to_term(input logic s,
                                                      input logic [EW-1:0] e,
                                                      input logic [MW-1:0] m);
    logic signed [ACC_W-1:0] mag;
    mag = ACC_W'(m);
    mag = mag << e;
    return s ? -mag : mag;
  endfunction

  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  assign p_sign   = product[PW-1];
  assign p_exp    = product[PW-2 -: EW];
  assign p_man    = product[MW-1:0];
  assign term     = to_term(p_sign, p_exp, p_man);
  assign sum_wide = {acc_p0[ACC_W-1], acc_p0} + {term[ACC_W-1], term};
  assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? DONE : ACCUM;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Accumulation stage: first beat loads, later beats add with saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0  <= '0;
      bias_p0 <= '0;
      cnt_p0  <= '0;
      ovf_p0  <= 1'b0;
      berr_p0 <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc_p0  <= term;
        bias_p0 <= in_shared_bias;
        cnt_p0  <= CNT_W'(1);
        ovf_p0  <= in_exp_overflow;
        berr_p0 <= 1'b0;
      end else begin
        acc_p0  <= saturate(sum_wide);
        ovf_p0  <= ovf_p0 | in_exp_overflow | sum_ovf;
        berr_p0 <= berr_p0 | (in_shared_bias != bias_p0);
        if (cnt_p0 != {CNT_W{1'b1}}) cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end
  end

  assign acc_out         = acc_p0;
  assign out_shared_bias = bias_p0;
  assign term_count      = cnt_p0;
  assign out_overflow    = ovf_p0;
  assign out_bias_err    = berr_p0;

endmodule

// File: tb/tb_bm_product_accumulator.sv
// Directed bench for bm_product_accumulator at default parameters.
module tb_bm_product_accumulator;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [14:0]        product;
  logic signed [2:0]  in_shared_bias;
  logic               in_exp_overflow;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] acc_out;
  logic signed [2:0]  out_shared_bias;
  logic [7:0]         term_count;
  logic               out_overflow;
  logic               out_bias_err;

  int n_cmp = 0;
  int n_err = 0;

  bm_product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .in_shared_bias(in_shared_bias),
    .in_exp_overflow(in_exp_overflow), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .out_shared_bias(out_shared_bias), .term_count(term_count),
    .out_overflow(out_overflow), .out_bias_err(out_bias_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic beat(input logic s, input logic [3:0] e, input logic [9:0] m,
                      input logic [2:0] b, input logic ov, input logic last);
    in_valid = 1'b1; product = {s, e, m}; in_shared_bias = b;
    in_exp_overflow = ov; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_exp_overflow = 1'b0;
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_release_valid: got %b want 0", tag, out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_release_ready: got %b want 1", tag, in_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; product = '0; in_shared_bias = '0;
    in_exp_overflow = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (acc_out !== 32'sd0) begin n_err++; $display("FAIL reset_acc: got %0d want 0", acc_out); end
    n_cmp++; if (term_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", term_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_cmp++; if ({out_overflow, out_bias_err, out_shared_bias} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b%b bias %0d want 00 bias 0", out_overflow, out_bias_err, out_shared_bias); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    beat(1'b0, 4'd0, 10'd256, 3'd2, 1'b0, 1'b0);
    beat(1'b1, 4'd1, 10'd256, 3'd2, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    n_cmp++; if (acc_out !== -32'sd256) begin n_err++; $display("FAIL basic_partial_acc: got %0d want -256", acc_out); end
    beat(1'b0, 4'd2, 10'd300, 3'd2, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready: got %b want 0", in_ready); end
    n_cmp++; if (acc_out !== 32'sd944) begin n_err++; $display("FAIL basic_acc: got %0d want 944", acc_out); end
    n_cmp++; if (term_count !== 8'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", term_count); end
    n_cmp++; if (out_shared_bias !== 3'sd2) begin n_err++; $display("FAIL basic_bias: got %0d want 2", out_shared_bias); end
    n_cmp++; if ({out_overflow, out_bias_err} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b%b want 00", out_overflow, out_bias_err); end
    release_result("basic");
  endtask

  task automatic test_single_negative();
    beat(1'b1, 4'd15, 10'd1023, 3'd0, 1'b0, 1'b1);
    n_cmp++; if (acc_out !== -32'sd33521664) begin n_err++; $display("FAIL single_acc: got %0d want -33521664", acc_out); end
    n_cmp++; if (term_count !== 8'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", term_count); end
    n_cmp++; if (out_overflow !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b want 0", out_overflow); end
    release_result("single");
  endtask

  task automatic test_saturation(input logic s);
    for (int i = 1; i <= 65; i++) beat(s, 4'd15, 10'd1023, 3'd0, 1'b0, i == 65);
    if (s) begin
      n_cmp++; if (acc_out !== 32'sh80000000) begin n_err++; $display("FAIL sat_neg_acc: got %0d want -2147483648", acc_out); end
    end else begin
      n_cmp++; if (acc_out !== 32'sd2147483647) begin n_err++; $display("FAIL sat_pos_acc: got %0d want 2147483647", acc_out); end
    end
    n_cmp++; if (out_overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b want 1", out_overflow); end
    n_cmp++; if (term_count !== 8'd65) begin n_err++; $display("FAIL sat_count: got %0d want 65", term_count); end
    release_result("sat");
  endtask

  task automatic test_bias_err();
    beat(1'b0, 4'd0, 10'd1, 3'b001, 1'b0, 1'b0);
    beat(1'b0, 4'd0, 10'd1, 3'b110, 1'b1, 1'b1);
    n_cmp++; if (out_bias_err !== 1'b1) begin n_err++; $display("FAIL bias_err: got %b want 1", out_bias_err); end
    n_cmp++; if (out_overflow !== 1'b1) begin n_err++; $display("FAIL bias_ovf: got %b want 1", out_overflow); end
    n_cmp++; if (out_shared_bias !== 3'sd1) begin n_err++; $display("FAIL bias_value: got %0d want 1", out_shared_bias); end
    n_cmp++; if (acc_out !== 32'sd2) begin n_err++; $display("FAIL bias_acc: got %0d want 2", acc_out); end
    release_result("bias");
  endtask

  task automatic test_gaps_and_count_sat();
    beat(1'b0, 4'd0, 10'd1, 3'd0, 1'b0, 1'b0);
    beat(1'b0, 4'd0, 10'd1, 3'd0, 1'b0, 1'b0);
    product = {1'b1, 4'd15, 10'd1023}; in_last = 1'b1; in_exp_overflow = 1'b1; in_shared_bias = 3'd3;
    repeat (3) @(posedge clk);
    #1; in_last = 1'b0; in_exp_overflow = 1'b0;
    n_cmp++; if (term_count !== 8'd2) begin n_err++; $display("FAIL gap_count: got %0d want 2", term_count); end
    n_cmp++; if (acc_out !== 32'sd2) begin n_err++; $display("FAIL gap_acc: got %0d want 2", acc_out); end
    n_cmp++; if ({out_valid, out_overflow, out_bias_err} !== 3'b000) begin
      n_err++; $display("FAIL gap_flags: got %b%b%b want 000", out_valid, out_overflow, out_bias_err); end
    for (int i = 3; i <= 300; i++) beat(1'b0, 4'd0, 10'd1, 3'd0, 1'b0, i == 300);
    n_cmp++; if (term_count !== 8'd255) begin n_err++; $display("FAIL cntsat_count: got %0d want 255", term_count); end
    n_cmp++; if (acc_out !== 32'sd300) begin n_err++; $display("FAIL cntsat_acc: got %0d want 300", acc_out); end
    release_result("cntsat");
  endtask

  task automatic test_done_hold();
    beat(1'b0, 4'd1, 10'd3, 3'd0, 1'b0, 1'b0);
    beat(1'b0, 4'd0, 10'd4, 3'd0, 1'b0, 1'b1);
    in_valid = 1'b1; product = {1'b0, 4'd2, 10'd7}; in_last = 1'b1; in_shared_bias = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL hold_handshake[%0d]: got valid %b ready %b want 1 0", i, out_valid, in_ready); end
      n_cmp++; if (acc_out !== 32'sd10 || term_count !== 8'd2) begin
        n_err++; $display("FAIL hold_data[%0d]: got acc %0d cnt %0d want 10 2", i, acc_out, term_count); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL hold_exit: got valid %b ready %b want 0 1", out_valid, in_ready); end
    n_cmp++; if (term_count !== 8'd2 || acc_out !== 32'sd10) begin
      n_err++; $display("FAIL hold_no_absorb: got acc %0d cnt %0d want 10 2", acc_out, term_count); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (acc_out !== 32'sd28 || term_count !== 8'd1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL hold_restart: got acc %0d cnt %0d valid %b want 28 1 1", acc_out, term_count, out_valid); end
    release_result("hold");
  endtask

  task automatic test_reset_mid();
    beat(1'b0, 4'd3, 10'd5, 3'd1, 1'b1, 1'b0);
    beat(1'b0, 4'd0, 10'd5, 3'd2, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (acc_out !== 32'sd0 || term_count !== 8'd0) begin
      n_err++; $display("FAIL rstmid_data: got acc %0d cnt %0d want 0 0", acc_out, term_count); end
    n_cmp++; if ({out_overflow, out_bias_err, out_shared_bias} !== 5'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmid_flags: got %b%b bias %0d ready %b want 00 0 1", out_overflow, out_bias_err, out_shared_bias, in_ready); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    beat(1'b1, 4'd2, 10'd9, 3'd3, 1'b0, 1'b1);
    n_cmp++; if (term_count !== 8'd1 || acc_out !== -32'sd36) begin
      n_err++; $display("FAIL rstmid_restart: got acc %0d cnt %0d want -36 1", acc_out, term_count); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || acc_out !== 32'sd0) begin
      n_err++; $display("FAIL rstdone: got valid %b acc %0d want 0 0", out_valid, acc_out); end
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstdone_after: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_negative();
    test_saturation(1'b0);
    test_saturation(1'b1);
    test_bias_err();
    test_gaps_and_count_sat();
    test_done_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
